// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding and constants for the data-memory responder.
package dmem_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
    localparam int LAT_W = 4;
    localparam logic ERR_NONE = 1'b0;
    localparam logic ERR_ACCESS = 1'b1;
endpackage

// File: rtl/dmem_if.sv
// dmem_if: LSU request/response bus between an initiator and the data-memory responder.
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_be;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_array.sv
// dmem_array: word RAM with byte-enable writes and a registered, clearable read port.
module dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic          clr,
    input  logic [3:0]    be,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH_WORDS];
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (we && be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        rdata <= re ? mem[idx] : clr ? '0 : rdata;
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated data-memory target for the LSU request/response bus.
module dmem_responder import dmem_pkg::*; #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input logic   clk,
    input logic   reset,
    dmem_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    state_t           state;
    logic [LAT_W-1:0] cnt;
    logic             we_q;
    logic [3:0]       be_q;
    logic [31:0]      addr_q, wdata_q;
    logic             fire, access, a_we, a_err, ram_we, ram_re, ram_clr;
    logic [3:0]       a_be;
    logic [31:0]      a_addr, a_wdata, a_off;
    // With zero wait states the access happens on the acceptance edge, so use the live request.
    always_comb begin
        fire    = bus.req_valid && bus.req_ready;
        a_we    = state == IDLE ? bus.req_we : we_q;
        a_be    = state == IDLE ? bus.req_be : be_q;
        a_addr  = state == IDLE ? bus.req_addr : addr_q;
        a_wdata = state == IDLE ? bus.req_wdata : wdata_q;
        a_off   = a_addr - BASE_ADDR;
        a_err   = |a_off[1:0] || a_addr < BASE_ADDR || {2'b00, a_off[31:2]} >= 32'(DEPTH_WORDS);
        access  = !reset && (state == IDLE ? fire && LATENCY == 0 : state == WAIT && cnt == LAT_W'(1));
        ram_we  = access && a_we && !a_err;
        ram_re  = access && !a_we && !a_err;
        ram_clr = reset || (state == RESP && bus.resp_ready) || access;
    end
    always_ff @(posedge clk) begin
        if (state == IDLE && fire) begin
            we_q    <= bus.req_we;
            be_q    <= bus.req_be;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= ERR_NONE;
        end else begin
            case (state)
                IDLE: if (fire) begin
                    cnt            <= LAT_W'(LATENCY);
                    bus.req_ready  <= 1'b0;
                    state          <= access ? RESP : WAIT;
                    bus.resp_valid <= access;
                    bus.resp_err   <= access && a_err ? ERR_ACCESS : ERR_NONE;
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (access) begin
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= a_err ? ERR_ACCESS : ERR_NONE;
                    end
                end
                RESP: if (bus.resp_ready) begin
                    state          <= IDLE;
                    bus.req_ready  <= 1'b1;
                    bus.resp_valid <= 1'b0;
                    bus.resp_err   <= ERR_NONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .clr   (ram_clr),
        .be    (a_be),
        .idx   (a_off[AW+1:2]),
        .wdata (a_wdata),
        .rdata (bus.resp_rdata)
    );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vectors and corner sequences against LATENCY 2, 0 and 3 instances.
module tb_dmem_responder;
    logic        clk = 1'b0, reset = 1'b1, valid = 1'b0, we = 1'b0, rready = 1'b1;
    logic [3:0]  be = '0;
    logic [31:0] addr = '0, wdata = '0;
    int          sel = 2;
    int          tests = 0, failed = 0;
    time         t_acc, t0;
    logic        rdy, rv, err;
    logic [31:0] rdata;

    dmem_if if0 (), if2 (), if3 ();
    assign if0.req_valid = valid && sel == 0;
    assign if2.req_valid = valid && sel == 2;
    assign if3.req_valid = valid && sel == 3;
    assign if0.req_we = we;       assign if2.req_we = we;       assign if3.req_we = we;
    assign if0.req_be = be;       assign if2.req_be = be;       assign if3.req_be = be;
    assign if0.req_addr = addr;   assign if2.req_addr = addr;   assign if3.req_addr = addr;
    assign if0.req_wdata = wdata; assign if2.req_wdata = wdata; assign if3.req_wdata = wdata;
    assign if0.resp_ready = rready; assign if2.resp_ready = rready; assign if3.resp_ready = rready;
    assign rdy   = sel == 0 ? if0.req_ready  : sel == 3 ? if3.req_ready  : if2.req_ready;
    assign rv    = sel == 0 ? if0.resp_valid : sel == 3 ? if3.resp_valid : if2.resp_valid;
    assign rdata = sel == 0 ? if0.resp_rdata : sel == 3 ? if3.resp_rdata : if2.resp_rdata;
    assign err   = sel == 0 ? if0.resp_err   : sel == 3 ? if3.resp_err   : if2.resp_err;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(0), .BASE_ADDR(32'h0)) u0 (.clk(clk), .reset(reset), .bus(if0));
    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(32'h0)) u2 (.clk(clk), .reset(reset), .bus(if2));
    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(3), .BASE_ADDR(32'h0)) u3 (.clk(clk), .reset(reset), .bus(if3));

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr, wdata, rdata;
        logic        err;
    } vec_t;
    vec_t v[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts and ends at a negedge; returns cycles from acceptance edge to resp_valid.
    task automatic xact(input logic w, input logic [3:0] b, input logic [31:0] a, d,
                        output int lat, output logic [31:0] rd, output logic e);
        int n = 0;
        valid = 1'b1; we = w; be = b; addr = a; wdata = d;
        while (!rdy && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        t_acc = $time;
        @(negedge clk);
        valid = 1'b0; we = 1'b1; be = 4'hF; addr = 32'h0000_0010; wdata = 32'hBAD0BAD0;
        lat = 1;
        while (!rv && lat < 50) begin @(negedge clk); lat++; end
        rd = rdata; e = err;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int lat;
        logic [31:0] rd;
        logic e, quiet;
        v[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEADBEEF, 32'h0, 1'b0};
        v[1]  = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 1'b0};
        v[2]  = '{1'b1, 4'h5, 32'h0000_0010, 32'h11223344, 32'h0, 1'b0};
        v[3]  = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,        32'hDE22BE44, 1'b0};
        v[4]  = '{1'b1, 4'hF, 32'h0000_0000, 32'h01234567, 32'h0, 1'b0};
        v[5]  = '{1'b0, 4'hF, 32'h0000_0013, 32'h0,        32'h0, 1'b1};
        v[6]  = '{1'b1, 4'hF, 32'h0000_1000, 32'hFFFFFFFF, 32'h0, 1'b1};
        v[7]  = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,        32'h01234567, 1'b0};
        v[8]  = '{1'b1, 4'h0, 32'h0000_0000, 32'hAAAAAAAA, 32'h0, 1'b0};
        v[9]  = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,        32'h01234567, 1'b0};
        v[10] = '{1'b1, 4'hF, 32'h0000_0FFC, 32'h5A5A5A5A, 32'h0, 1'b0};
        v[11] = '{1'b1, 4'h8, 32'h0000_0FFC, 32'h77000000, 32'h0, 1'b0};
        v[12] = '{1'b0, 4'hF, 32'h0000_0FFC, 32'h0,        32'h775A5A5A, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        check("reset_req_ready", 32'(rdy), 32'd1);
        check("reset_resp_valid", 32'(rv), 32'd0);
        check("reset_resp_rdata", rdata, 32'h0);
        check("reset_resp_err", 32'(err), 32'd0);

        for (int i = 0; i < 13; i++) begin
            xact(v[i].we, v[i].be, v[i].addr, v[i].wdata, lat, rd, e);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
            check($sformatf("vec%0d_rdata", i), rd, v[i].rdata);
            check($sformatf("vec%0d_err", i), 32'(e), 32'(v[i].err));
        end
        check("idle_after_table", 32'(rdy), 32'd1);

        // Response held under back-pressure; a write offered meanwhile must be ignored.
        rready = 1'b0;
        valid = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h0000_0010;
        @(posedge clk);
        @(negedge clk);
        we = 1'b1; wdata = 32'h0;
        lat = 1;
        while (!rv && lat < 50) begin @(negedge clk); lat++; end
        check("hold_latency", 32'(lat), 32'd3);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("hold%0d_valid", k), 32'(rv), 32'd1);
            check($sformatf("hold%0d_rdata", k), rdata, 32'hDE22BE44);
            check($sformatf("hold%0d_err", k), 32'(err), 32'd0);
            check($sformatf("hold%0d_req_ready", k), 32'(rdy), 32'd0);
            if (k < 4) @(negedge clk);
        end
        valid = 1'b0; rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_hs_req_ready", 32'(rdy), 32'd1);
        check("post_hs_resp_valid", 32'(rv), 32'd0);
        check("post_hs_rdata", rdata, 32'h0);
        xact(1'b0, 4'hF, 32'h0000_0010, 32'h0, lat, rd, e);
        check("held_off_write_rdata", rd, 32'hDE22BE44);

        // Zero wait states: one-cycle response, acceptances two cycles apart.
        sel = 0;
        xact(1'b1, 4'hF, 32'h0000_0000, 32'h11111111, lat, rd, e);
        check("l0_w0_latency", 32'(lat), 32'd1);
        xact(1'b1, 4'hF, 32'h0000_0004, 32'h22222222, lat, rd, e);
        xact(1'b0, 4'hF, 32'h0000_0000, 32'h0, lat, rd, e);
        t0 = t_acc;
        check("l0_r0_latency", 32'(lat), 32'd1);
        check("l0_r0_rdata", rd, 32'h11111111);
        xact(1'b0, 4'hF, 32'h0000_0004, 32'h0, lat, rd, e);
        check("l0_r4_latency", 32'(lat), 32'd1);
        check("l0_r4_rdata", rd, 32'h22222222);
        check("l0_issue_interval", 32'(t_acc - t0), 32'd20);

        // Reset one cycle after acceptance must abort the pending write.
        sel = 3;
        xact(1'b1, 4'hF, 32'h0000_0020, 32'h13572468, lat, rd, e);
        check("l3_w_latency", 32'(lat), 32'd4);
        valid = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h0000_0020; wdata = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0; reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_wait_req_ready", 32'(rdy), 32'd1);
        quiet = 1'b1;
        repeat (6) begin @(negedge clk); if (rv) quiet = 1'b0; end
        check("rst_wait_no_resp", 32'(quiet), 32'd1);
        xact(1'b0, 4'hF, 32'h0000_0020, 32'h0, lat, rd, e);
        check("rst_wait_latency", 32'(lat), 32'd4);
        check("rst_wait_rdata", rd, 32'h13572468);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the core's load/store path; the target end of the LSU request/response interface.
- Accepts one word-aligned request at a time: read, or byte-enabled write.
- Waits a programmable number of wait-state cycles, then returns read data and an error flag through a response handshake.
- Replaces the zero-latency data memory so that LSU and core stall logic can be exercised against realistic memory timing.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the backing array; must be a power of two.
- LATENCY, 2, wait-state cycles between request acceptance and the memory access; legal range 0..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to DEPTH_WORDS*4.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  the initiator presents a request.
- req_ready  output  1  the responder can accept a request this cycle.
- req_we  input  1  1 = write, 0 = read.
- req_be  input  4  byte enables for a write; bit i covers wdata[8i+7:8i]; ignored on reads.
- req_addr  input  32  byte address.
- req_wdata  input  32  write data, already lane-aligned by the LSU.
- resp_valid  output  1  a response is pending.
- resp_ready  input  1  the initiator accepts the response.
- resp_rdata  output  32  read data; 0 for writes and for errors.
- resp_err  output  1  misaligned or out-of-range access.

Behaviour:
- The single clock is clk. reset is synchronous and active-high.
- Reset values:
  - State is IDLE.
  - req_ready = 1 in the first cycle after reset is released.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - Array contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready at edge T, latch we, be, addr and wdata into request registers.
  - Go to WAIT with cnt = LATENCY when LATENCY > 0; go straight to ACCESS when LATENCY = 0.
- WAIT:
  - req_ready = 0.
  - cnt decrements each cycle; when cnt == 1, the next edge performs ACCESS.
- ACCESS (the edge that enters RESP):
  - The array write is committed, or the read word is registered into resp_rdata.
  - resp_err is registered on the same edge.
  - resp_valid rises.
- Timing: acceptance edge T gives resp_valid high in cycle T+1+LATENCY. With LATENCY = 0, the response appears the cycle after acceptance.
- RESP:
  - req_ready = 0.
  - resp_valid, resp_rdata and resp_err are held stable until resp_valid && resp_ready.
  - On that edge: state goes to IDLE, resp_valid = 0, and resp_rdata and resp_err are cleared to 0.
  - A new request cannot be accepted in the same cycle as the response handshake. Minimum issue interval is LATENCY+2 cycles.
- Error check (evaluated on the latched request):
  - The request is an error when addr[1:0] != 0, or addr < BASE_ADDR, or (addr - BASE_ADDR) >> 2 >= DEPTH_WORDS.
  - On error: no array write, resp_rdata = 0, resp_err = 1.
- Writes:
  - Only the bytes whose req_be bit is set are updated.
  - be = 4'b0000 is a legal no-op write with resp_err = 0.
  - resp_rdata = 0.
- Reads: return the full 32-bit word regardless of req_be. Sign/zero extension and lane selection stay in the LSU.
- Word index width is log2(DEPTH_WORDS). Address bits above the index are used only for the range check.
- Input changes:
  - req_* changes after acceptance have no effect.
  - req_valid while the responder is not ready is held off and causes no side effects.
- Reset mid-operation:
  - Reset asserted in WAIT returns the FSM to IDLE with no array write.
  - Reset asserted in RESP drops the response. A write already committed at ACCESS stays committed.
- resp_ready asserted with resp_valid = 0 is ignored.

Decomposition:
- Package dmem_pkg holds:
  - the state encoding (IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2);
  - the counter width constant LAT_W = 4;
  - the error-code constant.
- Sub-module dmem_array:
  - a DEPTH_WORDS x 32 synchronous RAM with 4-bit byte-enable write and registered read;
  - instantiated once;
  - driven only on the ACCESS edge.
- The FSM, counter, request registers and range check stay in dmem_responder.

Test Plan:
- Reset, LATENCY=2: write 0xDEADBEEF to 0x10 with be=4'hF, accepted at T, resp_ready held high.
  - Required: resp_valid in cycle T+3, resp_err=0.
  - Then a read of 0x10 returns resp_rdata=0xDEADBEEF at T'+3.
- Byte-enable write: 0x11223344 to 0x10 with be=4'b0101 over 0xDEADBEEF.
  - Required: a following read returns 0xDE22BE44.
- Errors:
  - Read of 0x13 gives resp_err=1, resp_rdata=0.
  - Write to 0x1000 with DEPTH_WORDS=1024 gives resp_err=1, and a read of 0x0 remains unchanged.
- Response hold: resp_ready held low for 5 cycles after resp_valid.
  - Required: resp_valid, resp_rdata and resp_err stable for all 5 cycles; req_ready=0 throughout.
  - req_ready returns to 1 the cycle after the handshake.
- LATENCY=0: back-to-back reads of 0x0 and 0x4 with resp_ready always high.
  - Required: each response one cycle after acceptance; acceptances 2 cycles apart.
- Reset in WAIT: write 0xCAFEF00D to 0x20, then assert reset one cycle after acceptance (LATENCY=3).
  - Required: no response, req_ready=1 after reset, and a read of 0x20 returns the prior contents.
